// File: rtl/rob_pkg.sv
// Shared types for the tagged reorder buffer.
//   slot_state_t : lifecycle of one buffer slot
//                  FREE -> ALLOC -> ISSUED -> DONE -> FREE
package rob_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ALLOC  = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } slot_state_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer for the reorder buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   inc      : advance the pointer by one
//   ptr      : full LD+1-bit value (wrap bit in the MSB, index below)
//   idx      : slot index, the low LD bits of ptr
module rob_ptr #(
    parameter int LD = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [LD:0]   ptr,
    output logic [LD-1:0] idx
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

    assign idx = ptr[LD-1:0];

endmodule

// File: rtl/tagged_rob.sv
// In-order-release reorder buffer for tagged memory-side transactions.
// Requests are allocated and issued in order, completions arrive by tag in
// any order, and entries retire in allocation order.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   alloc_valid/alloc_data/alloc_ready    : new request handshake
//   issue_valid/issue_tag/issue_data/
//   issue_ready                           : oldest un-issued request, downstream
//   cmpl_valid/cmpl_tag/cmpl_data         : completion by tag, always accepted
//   ret_valid/ret_req/ret_data/ret_ready  : head entry retire handshake
//   occupancy                             : allocated, not yet retired entries
//   err/err_tag                           : sticky bad-completion flag and the
//                                           tag of the first offender
module tagged_rob
    import rob_pkg::*;
#(
    parameter int LD     = 5,
    parameter int REQ_W  = 12,
    parameter int RESP_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REQ_W-1:0]  alloc_data,
    output logic              alloc_ready,
    output logic              issue_valid,
    output logic [LD-1:0]     issue_tag,
    output logic [REQ_W-1:0]  issue_data,
    input  logic              issue_ready,
    input  logic              cmpl_valid,
    input  logic [LD-1:0]     cmpl_tag,
    input  logic [RESP_W-1:0] cmpl_data,
    output logic              ret_valid,
    output logic [REQ_W-1:0]  ret_req,
    output logic [RESP_W-1:0] ret_data,
    input  logic              ret_ready,
    output logic [LD:0]       occupancy,
    output logic              err,
    output logic [LD-1:0]     err_tag
);

    localparam int         DEPTH    = 1 << LD;
    localparam logic [LD:0] FULL_OCC = {1'b1, {LD{1'b0}}};

    logic [LD:0]   tail_ptr, issue_ptr, head_ptr;
    logic [LD-1:0] tail_idx, issue_idx, head_idx;

    slot_state_t       state    [DEPTH];
    logic [REQ_W-1:0]  req_mem  [DEPTH];
    logic [RESP_W-1:0] resp_mem [DEPTH];

    logic alloc_fire, issue_fire, ret_fire;
    logic cmpl_ok, cmpl_bad;

    rob_ptr #(.LD(LD)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (alloc_fire),
        .ptr (tail_ptr),
        .idx (tail_idx)
    );

    rob_ptr #(.LD(LD)) u_issue (
        .clk (clk),
        .rst (rst),
        .inc (issue_fire),
        .ptr (issue_ptr),
        .idx (issue_idx)
    );

    rob_ptr #(.LD(LD)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (ret_fire),
        .ptr (head_ptr),
        .idx (head_idx)
    );

    // Wrap bits make tail - head exact over the full 0..DEPTH range.
    assign occupancy   = tail_ptr - head_ptr;
    // Depends only on registered pointers: a retire while full frees the
    // slot for the next cycle, never the current one.
    assign alloc_ready = (occupancy < FULL_OCC);

    assign issue_valid = (issue_ptr != tail_ptr);
    assign issue_tag   = issue_idx;
    assign issue_data  = req_mem[issue_idx];

    assign ret_valid   = (state[head_idx] == DONE);
    assign ret_req     = req_mem[head_idx];
    assign ret_data    = resp_mem[head_idx];

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign ret_fire    = ret_valid && ret_ready;

    // Only an outstanding (ISSUED) slot may complete; anything else is a
    // stray or duplicate completion.
    assign cmpl_ok     = cmpl_valid && (state[cmpl_tag] == ISSUED);
    assign cmpl_bad    = cmpl_valid && !cmpl_ok;

    // The four events always hit distinct slots, so their writes never
    // collide within one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state[i] <= FREE;
            end
            err     <= 1'b0;
            err_tag <= '0;
        end else begin
            if (alloc_fire) state[tail_idx]  <= ALLOC;
            if (issue_fire) state[issue_idx] <= ISSUED;
            if (cmpl_ok)    state[cmpl_tag]  <= DONE;
            if (ret_fire)   state[head_idx]  <= FREE;
            if (cmpl_bad) begin
                err <= 1'b1;
                if (!err) err_tag <= cmpl_tag;
            end
        end
    end

    // Payload storage carries no reset; slot state decides what is live.
    always_ff @(posedge clk) begin
        if (alloc_fire) req_mem[tail_idx]  <= alloc_data;
        if (cmpl_ok)    resp_mem[cmpl_tag] <= cmpl_data;
    end

endmodule

// File: doc/tagged_rob.md
# tagged_rob

Parametrised in-order-release reorder buffer for tagged memory-side transactions: allocates a tag per request in order, issues requests in order, accepts completions in any order by tag, and retires them in allocation order. It is the successor of the fixed 32-entry, 12-bit request/response ROB used by the stream buffer's TX path. Over that block it adds configurable depth and payload widths, ready/valid handshakes on all four sides, an explicit issue stage, occupancy reporting and stray/duplicate completion detection.

## Interface
- LD, 5: log2 of entry count; DEPTH = 2^LD; legal 1..8
- REQ_W, 12: request payload width
- RESP_W, 12: completion payload width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  new request offered
- alloc_data  in  REQ_W  request payload
- alloc_ready  out  1  entry available
- issue_valid  out  1  oldest un-issued request present
- issue_tag  out  LD  tag of that request
- issue_data  out  REQ_W  its payload
- issue_ready  in  1  downstream accepts issue
- cmpl_valid  in  1  completion present; always accepted
- cmpl_tag  in  LD  completion tag
- cmpl_data  in  RESP_W  completion payload
- ret_valid  out  1  head entry completed
- ret_req  out  REQ_W  head entry's original request payload
- ret_data  out  RESP_W  head entry's completion payload
- ret_ready  in  1  consumer accepts retire
- occupancy  out  LD+1  allocated, not yet retired entries
- err  out  1  sticky: bad completion seen
- err_tag  out  LD  tag of first bad completion

## Operation
- Three LD+1-bit pointers (wrap bit + index): alloc (tail), issue, retire (head). Invariant head <= issue <= tail, modulo 2^(LD+1).
- Per-slot state: FREE -> ALLOC (on allocate) -> ISSUED (on issue) -> DONE (on completion) -> FREE (on retire).
- Allocate when alloc_valid && alloc_ready: write alloc_data to slot tail, slot -> ALLOC, tail += 1.
- alloc_ready = occupancy < DEPTH. No same-cycle bypass: when full, a retire in cycle N raises alloc_ready in N+1.
- issue_valid = issue != tail; issue_tag = issue index; on issue_valid && issue_ready slot -> ISSUED, issue += 1.
- Completion: if slot cmpl_tag is ISSUED, store cmpl_data, slot -> DONE. Otherwise (FREE, ALLOC, DONE) ignore data, set err; if err was clear, capture err_tag = cmpl_tag.
- ret_valid = slot head is DONE; on ret_valid && ret_ready slot -> FREE, head += 1.
- occupancy = tail - head, LD+1 bits, wraps cleanly; reaches DEPTH exactly when full.
- All events (allocate, issue, completion, retire) may occur in the same cycle; they always target distinct slots or distinct states. Completion and retire never race on one slot, since retire needs DONE.

## Timing
- All outputs are combinational from registered state; there is no input-to-output combinational path except none-by-design (issue/ret handshakes do not feed alloc_ready in the same cycle).
- Minimum latency allocate -> issue_valid: 1 cycle. Completion -> ret_valid (head slot): 1 cycle.
- Full: alloc_ready=0 and alloc_valid is ignored. Empty: issue_valid=0, ret_valid=0.
- Reset values: all pointers 0, all slots FREE, occupancy 0, alloc_ready 1, issue_valid 0, ret_valid 0, err 0, err_tag 0. Payload RAMs are not reset.
- Reset mid-operation discards every outstanding entry. Completions in the reset cycle are dropped and do not set err.
- err and err_tag clear only on rst.

## Structure
- Package rob_pkg: slot_state_t enum {FREE, ALLOC, ISSUED, DONE} (2 bits).
- Request and completion payload arrays are plain registers/distributed RAM inline.
- Natural sub-module: rob_ptr (LD+1-bit wrap pointer with increment and index/wrap split), instantiated three times.

## Test plan
- LD=2: allocate 4 (payloads 0x1..0x4) with issue_ready=0 -> alloc_ready=0, occupancy=4; 5th alloc ignored; issue tags 0,1,2,3 in order.
- Issue 4, complete tags 3,1,0,2 -> ret_valid first rises 1 cycle after tag 0 completes; retire order req 0x1..0x4 paired with the matching cmpl_data.
- Full buffer, retire and allocate same cycle -> retire succeeds, allocate refused that cycle, accepted next; occupancy 4->3->4.
- Completion to ALLOC-state tag 2, then to DONE tag 1 -> err=1, err_tag=2, no state change, no spurious retire.
- Stream 1000 random transactions with random ready backpressure and completion shuffle -> scoreboard in-order match; pointers wrap, occupancy never exceeds 4.
- Assert rst with 3 entries outstanding -> next cycle occupancy=0, issue_valid=0, ret_valid=0, err=0; late completion to old tag sets err.
